// File: rtl/perf_pkg.sv
// Shared types and helpers for the performance counter report path.
package perf_pkg;

    localparam logic [7:0] PERF_HDR = 8'hA5;

    typedef enum logic [2:0] {
        IDLE,
        HDR,
        PAYLOAD,
        CSUM,
        DONE
    } perf_state_e;

    // Total frame length in bytes: header + two words + checksum.
    function automatic int unsigned frame_len(input int unsigned cnt_w);
        return 2 * (cnt_w / 8) + 2;
    endfunction

    // One step of the running payload checksum.
    function automatic logic [7:0] csum_step(input logic [7:0] acc, input logic [7:0] data);
        return acc ^ data;
    endfunction

endpackage

// File: rtl/byte_tx_reg.sv
// Single-entry valid/ready output register; holds the byte stable until accepted.
module byte_tx_reg (
    input  logic       clk,
    input  logic       rstn,
    input  logic       load_i,
    input  logic [7:0] data_i,
    input  logic       ready_i,
    output logic [7:0] data_o,
    output logic       valid_o
);

    logic [7:0] data_q;
    logic       valid_q;

    // Load a new byte (only when empty or on accept); otherwise drop valid once taken.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            data_q  <= 8'h00;
            valid_q <= 1'b0;
        end else if (load_i) begin
            data_q  <= data_i;
            valid_q <= 1'b1;
        end else if (valid_q && ready_i) begin
            valid_q <= 1'b0;
        end
    end

    assign data_o  = data_q;
    assign valid_o = valid_q;

endmodule

// File: rtl/perf_counter_reporter.sv
// Snapshots the cycle count and reference on trigger and streams them as a framed,
// checksummed byte sequence over a valid/ready link.
module perf_counter_reporter
    import perf_pkg::*;
#(
    parameter int unsigned CNT_W     = 32,
    parameter logic [7:0]  HEADER    = PERF_HDR,
    parameter bit          LSB_FIRST = 1'b1
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             trigger,
    input  logic [CNT_W-1:0] counter,
    input  logic [CNT_W-1:0] counter_value_reference,
    output logic [7:0]       tx_data,
    output logic             tx_valid,
    input  logic             tx_ready,
    output logic             busy,
    output logic             frame_done
);

    localparam int unsigned NB    = CNT_W / 8;
    localparam int unsigned NPAY  = frame_len(CNT_W) - 2;
    localparam int unsigned IDX_W = $clog2(NPAY);

    perf_state_e      state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] rf_q, rf_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [7:0]       csum_q, csum_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;

    logic             hs_c;
    logic             load_c;
    logic [7:0]       load_data_c;

    // Byte idx of {counter, reference}, each word ordered by LSB_FIRST.
    function automatic logic [7:0] payload_byte(input logic [CNT_W-1:0] cnt_w,
                                                input logic [CNT_W-1:0] rf_w,
                                                input logic [IDX_W-1:0] idx);
        logic [CNT_W-1:0] word;
        logic [IDX_W-1:0] pos;
        if (idx < IDX_W'(NB)) begin
            word = cnt_w;
            pos  = idx;
        end else begin
            word = rf_w;
            pos  = IDX_W'(idx - IDX_W'(NB));
        end
        if (!LSB_FIRST) begin
            pos = IDX_W'(IDX_W'(NB - 1) - pos);
        end
        return 8'(word >> {pos, 3'b000});
    endfunction

    assign hs_c = tx_valid && tx_ready;

    // State, snapshot and status registers.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            rf_q    <= '0;
            idx_q   <= '0;
            csum_q  <= 8'h00;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rf_q    <= rf_d;
            idx_q   <= idx_d;
            csum_q  <= csum_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    // Frame sequencing; each handshake loads the next byte into the output register.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        rf_d        = rf_q;
        idx_d       = idx_q;
        csum_d      = csum_q;
        busy_d      = busy_q;
        done_d      = 1'b0;
        load_c      = 1'b0;
        load_data_c = 8'h00;

        case (state_q)
            IDLE, DONE: begin
                busy_d  = 1'b0;
                state_d = IDLE;
                if (trigger) begin
                    cnt_d       = counter;
                    rf_d        = counter_value_reference;
                    csum_d      = 8'h00;
                    idx_d       = '0;
                    busy_d      = 1'b1;
                    load_c      = 1'b1;
                    load_data_c = HEADER;
                    state_d     = HDR;
                end
            end
            HDR: begin
                if (hs_c) begin
                    idx_d       = '0;
                    load_c      = 1'b1;
                    load_data_c = payload_byte(cnt_q, rf_q, '0);
                    state_d     = PAYLOAD;
                end
            end
            PAYLOAD: begin
                if (hs_c) begin
                    csum_d = csum_step(csum_q, tx_data);
                    load_c = 1'b1;
                    if (idx_q == IDX_W'(NPAY - 1)) begin
                        load_data_c = csum_d;
                        state_d     = CSUM;
                    end else begin
                        idx_d       = IDX_W'(idx_q + 1'b1);
                        load_data_c = payload_byte(cnt_q, rf_q, IDX_W'(idx_q + 1'b1));
                    end
                end
            end
            CSUM: begin
                if (hs_c) begin
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    state_d = DONE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    byte_tx_reg u_tx (
        .clk    (clk),
        .rstn   (rstn),
        .load_i (load_c),
        .data_i (load_data_c),
        .ready_i(tx_ready),
        .data_o (tx_data),
        .valid_o(tx_valid)
    );

    assign busy       = busy_q;
    assign frame_done = done_q;

endmodule

// File: tb/tb_perf_counter_reporter.sv
// Randomized self-checking bench for perf_counter_reporter (both byte orders).
module tb_perf_counter_reporter;

    typedef logic [7:0] byte_q_t[$];

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic        trigger = 1'b0;
    logic        tx_ready = 1'b0;
    logic [31:0] counter = 32'h0;
    logic [31:0] cref = 32'h0;

    logic [7:0]  tx_data_l, tx_data_m;
    logic        tx_valid_l, tx_valid_m;
    logic        busy_l, busy_m;
    logic        done_l, done_m;

    int n_checks = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    perf_counter_reporter #(.CNT_W(32), .HEADER(8'hA5), .LSB_FIRST(1'b1)) dut_l (
        .clk(clk), .rstn(rstn), .trigger(trigger), .counter(counter),
        .counter_value_reference(cref), .tx_data(tx_data_l), .tx_valid(tx_valid_l),
        .tx_ready(tx_ready), .busy(busy_l), .frame_done(done_l)
    );

    perf_counter_reporter #(.CNT_W(32), .HEADER(8'hA5), .LSB_FIRST(1'b0)) dut_m (
        .clk(clk), .rstn(rstn), .trigger(trigger), .counter(counter),
        .counter_value_reference(cref), .tx_data(tx_data_m), .tx_valid(tx_valid_m),
        .tx_ready(tx_ready), .busy(busy_m), .frame_done(done_m)
    );

    // Reference frame built directly from the frame definition.
    function automatic byte_q_t model_frame(input logic [31:0] c, input logic [31:0] r, input bit lsb);
        byte_q_t     f;
        logic [31:0] words[2];
        logic [7:0]  b;
        logic [7:0]  cs;
        words[0] = c;
        words[1] = r;
        cs = 8'h00;
        f.push_back(8'hA5);
        for (int w = 0; w < 2; w++) begin
            for (int k = 0; k < 4; k++) begin
                b = lsb ? 8'(words[w] >> (8 * k)) : 8'(words[w] >> (8 * (3 - k)));
                f.push_back(b);
                cs = cs ^ b;
            end
        end
        f.push_back(cs);
        return f;
    endfunction

    // Present inputs with a one-cycle trigger; returns inside the cycle after acceptance.
    task automatic start_frame(input logic [31:0] c, input logic [31:0] r);
        @(posedge clk); #1;
        counter = c;
        cref    = r;
        trigger = 1'b1;
        @(posedge clk); #1;
        trigger = 1'b0;
    endtask

    // Observes one frame cycle by cycle and reports what happened.
    task automatic run_frame(input bit msb, input int ready_pct, input int poke_cyc,
                             output byte_q_t got, output int first_v, output int last_acc,
                             output int done_cyc, output int dones, output int stalls,
                             output int busy_err, output int tail_valid);
        logic       v, r, d, b, pv, pr;
        logic [7:0] x, px;
        int         cyc;
        got = {};
        first_v = 0; last_acc = 0; done_cyc = 0; dones = 0;
        stalls = 0; busy_err = 0; tail_valid = 0;
        pv = 1'b0; pr = 1'b0; px = 8'h00;
        cyc = 0;
        while (cyc < 400 && !(done_cyc != 0 && cyc >= done_cyc + 3)) begin
            cyc++;
            @(negedge clk);
            v = msb ? tx_valid_m : tx_valid_l;
            x = msb ? tx_data_m : tx_data_l;
            d = msb ? done_m : done_l;
            b = msb ? busy_m : busy_l;
            r = tx_ready;
            if (v && first_v == 0) first_v = cyc;
            if (pv && !pr && (!v || x !== px)) stalls++;
            if (v && r) begin
                got.push_back(x);
                last_acc = cyc;
            end
            if (d) begin
                dones++;
                if (done_cyc == 0) done_cyc = cyc;
            end
            if (done_cyc != 0 && cyc > done_cyc && v) tail_valid++;
            if (done_cyc == 0 && !d && !b) busy_err++;
            if (d && b) busy_err++;
            pv = v; pr = r; px = x;
            @(posedge clk); #1;
            if (ready_pct < 100) tx_ready = ($urandom_range(99) < ready_pct);
            if (poke_cyc != 0 && cyc == poke_cyc) begin
                counter = 32'hFFFF_FFFF;
                cref    = 32'hFFFF_FFFF;
                trigger = 1'b1;
            end else if (poke_cyc != 0 && cyc == poke_cyc + 1) begin
                trigger = 1'b0;
            end
        end
    endtask

    task automatic test_reset();
        rstn = 1'b0;
        trigger = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        n_checks++;
        if ({tx_valid_l, tx_data_l, busy_l, done_l} !== 11'b0) begin
            n_fail++;
            $display("FAIL reset_lsb: valid=%b data=%h busy=%b done=%b, expected all zero",
                     tx_valid_l, tx_data_l, busy_l, done_l);
        end
        n_checks++;
        if ({tx_valid_m, tx_data_m, busy_m, done_m} !== 11'b0) begin
            n_fail++;
            $display("FAIL reset_msb: valid=%b data=%h busy=%b done=%b, expected all zero",
                     tx_valid_m, tx_data_m, busy_m, done_m);
        end
        @(posedge clk); #1;
        trigger = 1'b0;
        rstn = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        n_checks++;
        if (tx_valid_l !== 1'b0 || busy_l !== 1'b0) begin
            n_fail++;
            $display("FAIL idle_after_reset: valid=%b busy=%b, expected 0 0", tx_valid_l, busy_l);
        end
    endtask

    task automatic test_basic();
        logic [7:0] exp_b[10] = '{8'hA5, 8'h05, 8'h00, 8'h00, 8'h00, 8'h78, 8'h56, 8'h34, 8'h12, 8'h0D};
        byte_q_t got;
        int fv, la, dc, dn, st, be, tv;
        tx_ready = 1'b1;
        start_frame(32'h0000_0005, 32'h1234_5678);
        run_frame(1'b0, 100, 0, got, fv, la, dc, dn, st, be, tv);
        n_checks++;
        if (got.size() != 10) begin
            n_fail++;
            $display("FAIL basic_len: got %0d bytes, expected 10", got.size());
        end
        for (int i = 0; i < 10 && i < got.size(); i++) begin
            n_checks++;
            if (got[i] !== exp_b[i]) begin
                n_fail++;
                $display("FAIL basic_byte%0d: got %h, expected %h", i, got[i], exp_b[i]);
            end
        end
        n_checks++;
        if (fv != 1 || la != 10 || dc != 11) begin
            n_fail++;
            $display("FAIL basic_timing: first_valid=%0d last_accept=%0d done=%0d, expected 1 10 11", fv, la, dc);
        end
        n_checks++;
        if (dn != 1 || be != 0 || tv != 0) begin
            n_fail++;
            $display("FAIL basic_status: dones=%0d busy_err=%0d tail_valid=%0d, expected 1 0 0", dn, be, tv);
        end
    endtask

    task automatic test_backpressure();
        byte_q_t got, exp;
        int fv, la, dc, dn, st, be, tv;
        exp = model_frame(32'h0000_0005, 32'h1234_5678, 1'b1);
        for (int rep = 0; rep < 3; rep++) begin
            tx_ready = 1'b1;
            start_frame(32'h0000_0005, 32'h1234_5678);
            tx_ready = 1'b0;
            run_frame(1'b0, 45, 0, got, fv, la, dc, dn, st, be, tv);
            n_checks++;
            if (got != exp) begin
                n_fail++;
                $display("FAIL bp_frame%0d: got %p, expected %p", rep, got, exp);
            end
            n_checks++;
            if (st != 0 || dn != 1 || be != 0 || dc == 0) begin
                n_fail++;
                $display("FAIL bp_status%0d: stalls=%0d dones=%0d busy_err=%0d done_cyc=%0d, expected 0 1 0 nonzero",
                         rep, st, dn, be, dc);
            end
        end
        tx_ready = 1'b1;
    endtask

    task automatic test_snapshot();
        byte_q_t got, exp;
        int fv, la, dc, dn, st, be, tv;
        exp = model_frame(32'h0000_0005, 32'h1234_5678, 1'b1);
        tx_ready = 1'b1;
        start_frame(32'h0000_0005, 32'h1234_5678);
        run_frame(1'b0, 100, 3, got, fv, la, dc, dn, st, be, tv);
        n_checks++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL snapshot_frame: got %p, expected %p", got, exp);
        end
        n_checks++;
        if (dn != 1 || tv != 0) begin
            n_fail++;
            $display("FAIL snapshot_no_restart: dones=%0d tail_valid=%0d, expected 1 0", dn, tv);
        end
    endtask

    task automatic test_back_to_back();
        byte_q_t    ea, eb;
        logic       v, d, ev, ed;
        logic [7:0] x, ex;
        ea = model_frame(32'hCAFE_0001, 32'h0BAD_F00D, 1'b1);
        eb = model_frame(32'h1357_9BDF, 32'h2468_ACE0, 1'b1);
        tx_ready = 1'b1;
        @(posedge clk); #1;
        counter = 32'hCAFE_0001;
        cref    = 32'h0BAD_F00D;
        trigger = 1'b1;
        @(posedge clk); #1;
        for (int cyc = 1; cyc <= 24; cyc++) begin
            @(negedge clk);
            v = tx_valid_l; d = done_l; x = v ? tx_data_l : 8'h00;
            ev = 1'b0; ed = 1'b0; ex = 8'h00;
            if (cyc <= 10) begin
                ev = 1'b1; ex = ea[cyc-1];
            end else if (cyc == 11 || cyc == 22) begin
                ed = 1'b1;
            end else if (cyc <= 21) begin
                ev = 1'b1; ex = eb[cyc-12];
            end
            n_checks++;
            if ({v, d, x} !== {ev, ed, ex}) begin
                n_fail++;
                $display("FAIL b2b_cyc%0d: valid=%b done=%b data=%h, expected %b %b %h", cyc, v, d, x, ev, ed, ex);
            end
            @(posedge clk); #1;
            if (cyc == 5) begin
                counter = 32'h1357_9BDF;
                cref    = 32'h2468_ACE0;
            end
            if (cyc == 12) trigger = 1'b0;
        end
    endtask

    task automatic test_msb_first();
        logic [7:0] exp_b[10] = '{8'hA5, 8'h01, 8'h02, 8'h03, 8'h04, 8'hA0, 8'hB0, 8'hC0, 8'hD0, 8'h04};
        byte_q_t got;
        int fv, la, dc, dn, st, be, tv;
        tx_ready = 1'b1;
        start_frame(32'h0102_0304, 32'hA0B0_C0D0);
        run_frame(1'b1, 70, 0, got, fv, la, dc, dn, st, be, tv);
        n_checks++;
        if (got.size() != 10) begin
            n_fail++;
            $display("FAIL msb_len: got %0d bytes, expected 10", got.size());
        end
        for (int i = 0; i < 10 && i < got.size(); i++) begin
            n_checks++;
            if (got[i] !== exp_b[i]) begin
                n_fail++;
                $display("FAIL msb_byte%0d: got %h, expected %h", i, got[i], exp_b[i]);
            end
        end
        n_checks++;
        if (st != 0 || dn != 1) begin
            n_fail++;
            $display("FAIL msb_status: stalls=%0d dones=%0d, expected 0 1", st, dn);
        end
        tx_ready = 1'b1;
    endtask

    task automatic test_reset_mid_frame();
        byte_q_t got, exp;
        int fv, la, dc, dn, st, be, tv;
        int stray;
        tx_ready = 1'b1;
        start_frame(32'h7777_8888, 32'h9999_AAAA);
        repeat (3) @(posedge clk);
        #1;
        @(negedge clk);
        n_checks++;
        if (tx_valid_l !== 1'b1 || busy_l !== 1'b1) begin
            n_fail++;
            $display("FAIL midrst_pre: valid=%b busy=%b, expected 1 1", tx_valid_l, busy_l);
        end
        @(posedge clk); #1;
        rstn = 1'b0;
        @(negedge clk);
        @(negedge clk);
        n_checks++;
        if ({tx_valid_l, busy_l, done_l} !== 3'b000) begin
            n_fail++;
            $display("FAIL midrst_abort: valid=%b busy=%b done=%b, expected 000", tx_valid_l, busy_l, done_l);
        end
        @(posedge clk); #1;
        rstn = 1'b1;
        stray = 0;
        repeat (4) begin
            @(negedge clk);
            if (done_l || tx_valid_l) stray++;
        end
        n_checks++;
        if (stray != 0) begin
            n_fail++;
            $display("FAIL midrst_quiet: %0d cycles with valid/done, expected 0", stray);
        end
        exp = model_frame(32'h0000_0042, 32'hDEAD_BEEF, 1'b1);
        start_frame(32'h0000_0042, 32'hDEAD_BEEF);
        run_frame(1'b0, 100, 0, got, fv, la, dc, dn, st, be, tv);
        n_checks++;
        if (got != exp || dn != 1 || fv != 1) begin
            n_fail++;
            $display("FAIL midrst_next: got %p dones=%0d first=%0d, expected %p 1 1", got, dn, fv, exp);
        end
    endtask

    task automatic test_random();
        byte_q_t     got, exp;
        int          fv, la, dc, dn, st, be, tv;
        logic [31:0] c, r;
        bit          msb;
        int          pct;
        for (int n = 0; n < 6; n++) begin
            c   = $urandom;
            r   = $urandom;
            msb = n[0];
            pct = 30 + int'($urandom_range(70));
            exp = model_frame(c, r, !msb);
            tx_ready = $urandom_range(1);
            start_frame(c, r);
            run_frame(msb, pct, 0, got, fv, la, dc, dn, st, be, tv);
            n_checks++;
            if (got != exp) begin
                n_fail++;
                $display("FAIL rand%0d_frame: got %p, expected %p", n, got, exp);
            end
            n_checks++;
            if (st != 0 || dn != 1 || be != 0 || tv != 0) begin
                n_fail++;
                $display("FAIL rand%0d_status: stalls=%0d dones=%0d busy_err=%0d tail=%0d, expected 0 1 0 0",
                         n, st, dn, be, tv);
            end
        end
        tx_ready = 1'b1;
    endtask

    initial begin
        test_reset();
        test_basic();
        test_backpressure();
        test_snapshot();
        test_back_to_back();
        test_msb_first();
        test_reset_mid_frame();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
